ram_stream_reader: RTL

- Read-side engine for the team's inferable dual-port RAMs, targeting the synchronous-read variant with 1-cycle read latency.
- On a start command it reads a contiguous block of words from the RAM read port and emits them as a valid/ready stream with a Last marker.
- It pairs with producers that fill the RAM through its write port, for example DMA or trace capture logic.
- It absorbs the RAM read latency and downstream backpressure using a 3-entry output buffer and credit-based read issue.

---
 rtl/ram_stream_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a contiguous block of words out of a
// synchronous-read RAM (1-cycle latency) as a valid/ready stream with Last.
module ram_stream_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Start_SI,
    input  logic [ADDR_WIDTH-1:0] StartAddr_DI,
    input  logic [LEN_WIDTH-1:0]  Len_DI,
    output logic                  Busy_SO,
    output logic                  Done_SO,
    output logic                  RdEn_SO,
    output logic [ADDR_WIDTH-1:0] RdAddr_DO,
    input  logic [DATA_WIDTH-1:0] RdData_DI,
    output logic                  Valid_SO,
    input  logic                  Ready_SI,
    output logic [DATA_WIDTH-1:0] Data_DO,
    output logic                  Last_SO
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    issued;
    logic                    done_q;

    // read pipeline: a read issued last cycle returns data this cycle
    logic                    inflight;
    logic                    inflight_last;

    // 3-entry output buffer
    logic [DATA_WIDTH-1:0]   buf_data [3];
    logic [2:0]              buf_last;
    logic [1:0]              buf_count;
    logic [1:0]              head;
    logic [1:0]              tail;
    logic                    valid_q;

    logic                    rd_en;
    logic                    issue_last;
    logic                    push;
    logic                    pop;
    logic                    beat_last;
    logic [1:0]              count_next;
    logic [2:0]              credit_used;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // credit check: buffered words plus the word still in the RAM
    // pipeline must leave room for one more read
    always_comb begin
        credit_used = {1'b0, buf_count} + {2'b00, inflight};
        rd_en       = 1'b0;
        if (state == RUN && issued < len_q && credit_used <= 3'd2) begin
            rd_en = 1'b1;
        end
        issue_last = (issued == len_q - LEN_ONE);
    end

    // buffer push/pop decode and next occupancy
    always_comb begin
        push       = inflight;
        pop        = valid_q && Ready_SI;
        beat_last  = buf_last[head];
        count_next = buf_count;
        unique case ({push, pop})
            2'b10:   count_next = buf_count + 2'd1;
            2'b01:   count_next = buf_count - 2'd1;
            default: count_next = buf_count;
        endcase
    end

    // control FSM: start acceptance, read address/count, completion pulse
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state   <= IDLE;
            rd_addr <= '0;
            len_q   <= '0;
            issued  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Start_SI) begin
                        if (Len_DI == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            rd_addr <= StartAddr_DI;
                            len_q   <= Len_DI;
                            issued  <= '0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        issued  <= issued + LEN_ONE;
                        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
                        if (issue_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && beat_last) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // track the read in the RAM pipeline and whether it is the final word
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= rd_en;
            inflight_last <= rd_en && issue_last;
        end
    end

    // output buffer storage: capture returning data, advance on handshake
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < 3; i++) begin
                buf_data[i] <= '0;
            end
            buf_last  <= '0;
            buf_count <= '0;
            head      <= '0;
            tail      <= '0;
            valid_q   <= 1'b0;
        end else begin
            if (push) begin
                buf_data[tail] <= RdData_DI;
                buf_last[tail] <= inflight_last;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            buf_count <= count_next;
            valid_q   <= (count_next != 2'd0);
        end
    end

    assign Busy_SO   = (state != IDLE);
    assign Done_SO   = done_q;
    assign RdEn_SO   = rd_en;
    assign RdAddr_DO = rd_addr;
    assign Valid_SO  = valid_q;
    assign Data_DO   = buf_data[head];
    assign Last_SO   = valid_q && beat_last;

`ifndef SYNTHESIS
    // start arguments must describe a block inside the RAM
    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI && state == IDLE && Start_SI) begin
            assert (int'(Len_DI) <= DATA_DEPTH);
            assert (int'(StartAddr_DI) < DATA_DEPTH);
        end
    end

    // the credit scheme must never overfill the buffer
    always_ff @(posedge Clk_CI) begin
        if (Rst_RBI) begin
            assert (!(push && !pop && buf_count == 2'd3));
        end
    end
`endif

endmodule
